// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DEF_XLEN   = 64;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_XLEN-1:0]   xlen_t;

  localparam reg_addr_t REG_ZERO = '0;

  // One writeback request as seen after the source mux.
  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    xlen_t     data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: per-source request/grant handshake plus the single
// register-file write port driven by the arbiter.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = DEF_XLEN,
  parameter int ADDR_W  = DEF_ADDR_W
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*ADDR_W-1:0] src_rd_addr;
  logic [NUM_SRC*XLEN-1:0]   src_rd_data;
  logic                      regCtrl_wen;
  logic [ADDR_W-1:0]         regCtrl_rdAddr;
  logic [XLEN-1:0]           rdData;

  // Writeback sources and register-file side.
  modport master (
    output src_valid, src_rd_addr, src_rd_data,
    input  src_ready, regCtrl_wen, regCtrl_rdAddr, rdData
  );

  // Arbiter side.
  modport slave (
    input  src_valid, src_rd_addr, src_rd_data,
    output src_ready, regCtrl_wen, regCtrl_rdAddr, rdData
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches req starting at ptr, wrapping modulo
// NUM_SRC, and grants the first requester found.
module rr_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  int idx;

  // Rotating priority search; first hit from ptr wins, so grant is one-hot.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!gnt_vld && req[IDX_W'(idx)]) begin
        gnt_vld             = 1'b1;
        gnt[IDX_W'(idx)]    = 1'b1;
        gnt_idx             = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with a registered write port and the
// busy-register scoreboard used by decode for RAW stall detection.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = DEF_XLEN,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                clock,
  input  logic                reset,
  regfile_wb_arbiter_if.slave wb,
  input  logic                alloc_valid,
  input  logic [ADDR_W-1:0]   alloc_addr,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   chk_addr1,
  input  logic [ADDR_W-1:0]   chk_addr2,
  output logic                chk_busy1,
  output logic                chk_busy2,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam int IDX_W = $clog2(NUM_SRC);

  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    gnt_idx;
  logic [NUM_SRC-1:0]  gnt;
  logic                gnt_vld;
  logic                hs;
  wb_req_t             sel;
  logic                wen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     data_q;
  logic [NUM_REGS-1:0] busy_nxt;

  rr_arbiter #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_arb (
    .req     (wb.src_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Grant only implies a handshake outside reset; ready is held low in reset.
  assign hs           = gnt_vld & reset;
  assign wb.src_ready = gnt & {NUM_SRC{reset}};

  // Mux the granted source's destination and data.
  always_comb begin
    sel       = '0;
    sel.valid = hs;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        sel.addr = wb.src_rd_addr[i*ADDR_W +: ADDR_W];
        sel.data = wb.src_rd_data[i*XLEN +: XLEN];
      end
    end
  end

  // Rotate priority to just past the last winner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (gnt_idx == IDX_W'(NUM_SRC-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Output stage: x0 writes still consume the grant but never enable the write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wen_q <= sel.valid && (sel.addr != REG_ZERO);
      if (sel.valid) begin
        addr_q <= sel.addr;
        data_q <= sel.data;
      end
    end
  end

  assign wb.regCtrl_wen    = wen_q;
  assign wb.regCtrl_rdAddr = addr_q;
  assign wb.rdData         = data_q;

  // Scoreboard next state: clear on write, set on issue (set wins), flush wipes all.
  always_comb begin
    busy_nxt = busy_vec;
    if (wen_q) busy_nxt[addr_q] = 1'b0;
    if (alloc_valid && (alloc_addr != REG_ZERO)) busy_nxt[alloc_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_vec <= '0;
    else        busy_vec <= busy_nxt;
  end

  assign chk_busy1 = busy_vec[chk_addr1];
  assign chk_busy2 = busy_vec[chk_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations
// followed by random traffic, all checked every cycle against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int XW = 64;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          alloc_valid = 1'b0;
  logic [AW-1:0] alloc_addr = '0;
  logic          flush = 1'b0;
  logic [AW-1:0] chk_addr1 = '0;
  logic [AW-1:0] chk_addr2 = '0;
  logic          chk_busy1, chk_busy2;
  logic [31:0]   busy_vec;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter_if #(.NUM_SRC(N), .XLEN(XW), .ADDR_W(AW)) wb ();

  regfile_wb_arbiter #(.NUM_SRC(N), .XLEN(XW), .ADDR_W(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .wb          (wb),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .flush       (flush),
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .chk_busy1   (chk_busy1),
    .chk_busy2   (chk_busy2),
    .busy_vec    (busy_vec)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid source at or after p, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  int          m_ptr  = 0;
  bit          m_wen  = 0;
  bit [AW-1:0] m_addr = '0;
  bit [XW-1:0] m_data = '0;
  bit [31:0]   m_busy = '0;
  int          mg;
  bit [31:0]   nb;
  bit [AW-1:0] ma;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ptr = 0; m_wen = 0; m_addr = '0; m_data = '0; m_busy = '0;
    end else begin
      nb = m_busy;
      if (m_wen) nb[m_addr] = 1'b0;
      if (alloc_valid && alloc_addr != 0) nb[alloc_addr] = 1'b1;
      if (flush) nb = '0;
      m_busy = nb;
      mg = pick(wb.src_valid, m_ptr);
      if (mg >= 0) begin
        ma     = wb.src_rd_addr[mg*AW +: AW];
        m_wen  = (ma != 0);
        m_addr = ma;
        m_data = wb.src_rd_data[mg*XW +: XW];
        m_ptr  = (mg + 1) % N;
      end else begin
        m_wen = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [N-1:0] exp_rdy;
  int           cg;
  always @(negedge clock) begin
    exp_rdy = '0;
    if (reset) begin
      cg = pick(wb.src_valid, m_ptr);
      if (cg >= 0) exp_rdy[cg] = 1'b1;
    end
    chk("src_ready", 64'(wb.src_ready), 64'(exp_rdy));
    chk("wen", 64'(wb.regCtrl_wen), 64'(m_wen));
    chk("rdAddr", 64'(wb.regCtrl_rdAddr), 64'(m_addr));
    chk("rdData", wb.rdData, m_data);
    chk("busy_vec", 64'(busy_vec), 64'(m_busy));
    chk("chk_busy1", 64'(chk_busy1), 64'(m_busy[chk_addr1]));
    chk("chk_busy2", 64'(chk_busy2), 64'(m_busy[chk_addr2]));
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] hs;

  task automatic tick();
    @(negedge clock); #1;
    hs = wb.src_valid & wb.src_ready;
    @(posedge clock); #1;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [XW-1:0] d);
    wb.src_rd_addr[i*AW +: AW] = a;
    wb.src_rd_data[i*XW +: XW] = d;
  endtask

  initial begin
    wb.src_valid   = '0;
    wb.src_rd_addr = '0;
    wb.src_rd_data = '0;
    hs             = '0;

    // Reset state, with requests present.
    wb.src_valid = 3'b111;
    set_src(0, 5'd1, 64'h1); set_src(1, 5'd2, 64'h2); set_src(2, 5'd3, 64'h3);
    @(posedge clock); #2;
    chk("rst_ready", 64'(wb.src_ready), 64'h0);
    chk("rst_wen", 64'(wb.regCtrl_wen), 64'h0);
    chk("rst_addr", 64'(wb.regCtrl_rdAddr), 64'h0);
    chk("rst_data", wb.rdData, 64'h0);
    chk("rst_busy", 64'(busy_vec), 64'h0);
    wb.src_valid = '0;
    @(posedge clock); #1;
    reset = 1'b1;

    // Single source.
    wb.src_valid = 3'b001; set_src(0, 5'd5, 64'hDEAD);
    #1 chk("single_ready", 64'(wb.src_ready), 64'b001);
    tick(); wb.src_valid = '0;
    chk("single_wen", 64'(wb.regCtrl_wen), 64'h1);
    chk("single_addr", 64'(wb.regCtrl_rdAddr), 64'd5);
    chk("single_data", wb.rdData, 64'hDEAD);
    tick();
    chk("single_wen_off", 64'(wb.regCtrl_wen), 64'h0);

    // Bring the pointer back to 0 via source 2.
    wb.src_valid = 3'b100; set_src(2, 5'd1, 64'h1);
    tick(); wb.src_valid = '0;
    chk("model_ptr_p0", 64'(m_ptr), 64'd0);

    // Fairness: all valid for 6 cycles.
    wb.src_valid = 3'b111;
    for (int i = 0; i < N; i++) set_src(i, AW'(10 + i), 64'(i * 'h111));
    for (int c = 0; c < 6; c++) begin
      logic [N-1:0] er;
      er = '0; er[c % 3] = 1'b1;
      #1;
      chk("fair_ready", 64'(wb.src_ready), 64'(er));
      if (c > 0) chk("fair_wen", 64'(wb.regCtrl_wen), 64'h1);
      tick();
      set_src(c % 3, AW'(13 + c), 64'(c + 'h500));
    end
    wb.src_valid = '0;
    chk("fair_wen_last", 64'(wb.regCtrl_wen), 64'h1);

    // x0 write.
    wb.src_valid = 3'b010; set_src(1, 5'd0, 64'hFF);
    #1 chk("x0_ready", 64'(wb.src_ready), 64'b010);
    tick(); wb.src_valid = '0;
    chk("x0_wen", 64'(wb.regCtrl_wen), 64'h0);
    chk("model_ptr_x0", 64'(m_ptr), 64'd2);
    wb.src_valid = 3'b111;
    set_src(0, 5'd20, 64'h20); set_src(1, 5'd21, 64'h21); set_src(2, 5'd12, 64'h12);
    #1 chk("x0_next_ready", 64'(wb.src_ready), 64'b100);
    tick(); wb.src_valid = '0;

    // Scoreboard set then clear by LSU write.
    alloc_valid = 1'b1; alloc_addr = 5'd7; chk_addr1 = 5'd7;
    #1 chk("sb_nobypass", 64'(chk_busy1), 64'h0);
    tick(); alloc_valid = 1'b0;
    chk("sb_set", 64'(chk_busy1), 64'h1);
    tick();
    tick();
    wb.src_valid = 3'b010; set_src(1, 5'd7, 64'h77);
    tick(); wb.src_valid = '0;
    chk("sb_wen", 64'(wb.regCtrl_wen), 64'h1);
    chk("sb_wen_addr", 64'(wb.regCtrl_rdAddr), 64'd7);
    chk("sb_still_busy", 64'(chk_busy1), 64'h1);
    tick();
    chk("sb_cleared", 64'(chk_busy1), 64'h0);

    // Set/clear collision on register 9.
    wb.src_valid = 3'b001; set_src(0, 5'd9, 64'h9);
    tick(); wb.src_valid = '0;
    alloc_valid = 1'b1; alloc_addr = 5'd9;
    tick(); alloc_valid = 1'b0;
    chk("coll_set_wins", 64'(busy_vec[9]), 64'h1);

    // Same collision with flush.
    wb.src_valid = 3'b010; set_src(1, 5'd9, 64'h99);
    alloc_valid = 1'b1; alloc_addr = 5'd4;
    tick(); wb.src_valid = '0;
    alloc_addr = 5'd9; flush = 1'b1;
    chk("flush_wen", 64'(wb.regCtrl_wen), 64'h1);
    tick(); alloc_valid = 1'b0; flush = 1'b0;
    chk("flush_busy", 64'(busy_vec), 64'h0);

    // Flush in the handshake cycle does not cancel the write.
    wb.src_valid = 3'b100; set_src(2, 5'd6, 64'h66); flush = 1'b1;
    tick(); wb.src_valid = '0; flush = 1'b0;
    chk("flush_pend_wen", 64'(wb.regCtrl_wen), 64'h1);
    chk("flush_pend_addr", 64'(wb.regCtrl_rdAddr), 64'd6);

    // Async reset mid-cycle.
    alloc_valid = 1'b1; alloc_addr = 5'd7;
    tick();
    alloc_addr = 5'd8;
    wb.src_valid = 3'b001; set_src(0, 5'd3, 64'h33);
    tick(); wb.src_valid = '0; alloc_valid = 1'b0;
    chk("ar_busy_pre", 64'(busy_vec), 64'h180);
    chk("ar_wen_pre", 64'(wb.regCtrl_wen), 64'h1);
    #1 reset = 1'b0;
    #1;
    chk("ar_wen", 64'(wb.regCtrl_wen), 64'h0);
    chk("ar_busy", 64'(busy_vec), 64'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    wb.src_valid = 3'b100; set_src(2, 5'd2, 64'h22);
    #1 chk("ar_first_ready", 64'(wb.src_ready), 64'b100);
    tick();
    wb.src_valid = 3'b111;
    #1 chk("ar_p0_ready", 64'(wb.src_ready), 64'b001);
    chk("model_ptr_ar", 64'(m_ptr), 64'd0);
    tick(); wb.src_valid = '0;
    tick();

    // Random traffic; sources hold requests until their handshake.
    hs = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!wb.src_valid[i] || hs[i]) begin
          wb.src_valid[i] = ($urandom_range(2) != 0);
          set_src(i, ($urandom_range(7) == 0) ? AW'(0) : AW'($urandom_range(31)),
                  {$urandom, $urandom});
        end
      end
      alloc_valid = $urandom_range(1) == 1;
      alloc_addr  = AW'($urandom_range(31));
      flush       = ($urandom_range(31) == 0);
      chk_addr1   = AW'($urandom_range(31));
      chk_addr2   = AW'($urandom_range(31));
      tick();
    end
    wb.src_valid = '0; alloc_valid = 1'b0; flush = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (regCtrl_wen / regCtrl_rdAddr / rdData) between NUM_SRC writeback sources (EXU, LSU, CSR), using round-robin arbitration and a registered output stage.
- Also holds the busy-register scoreboard: issue marks a destination busy, and the matching register-file write clears it. Decode queries it for RAW stalls.
- Sits between the writeback sources and the register file.

Parameters:
NUM_SRC, 3, number of writeback requesters (2..8)
XLEN, 64, data width
ADDR_W, 5, register address width (32 registers)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
src_valid  in  NUM_SRC  per-source write request
src_ready  out  NUM_SRC  per-source grant (handshake = valid & ready)
src_rd_addr  in  NUM_SRC*ADDR_W  per-source destination, source i at bits [i*ADDR_W +: ADDR_W]
src_rd_data  in  NUM_SRC*XLEN  per-source data, same packing
regCtrl_wen  out  1  register-file write enable
regCtrl_rdAddr  out  ADDR_W  register-file write address
rdData  out  XLEN  register-file write data
alloc_valid  in  1  issue marks a destination busy
alloc_addr  in  ADDR_W  destination being allocated
flush  in  1  clears all busy bits (pipeline redirect)
chk_addr1  in  ADDR_W  decode rs1 query
chk_addr2  in  ADDR_W  decode rs2 query
chk_busy1  out  1  busy[chk_addr1], combinational
chk_busy2  out  1  busy[chk_addr2], combinational
busy_vec  out  32  full scoreboard, registered

Behaviour:
- Reset (reset low, asynchronous):
  - regCtrl_wen=0, regCtrl_rdAddr=0, rdData=0
  - busy_vec=0, round-robin pointer=0
  - src_ready=0 while reset is asserted
- Arbitration (combinational):
  - Search starts at pointer p and runs p, p+1, ..., wrapping modulo NUM_SRC.
  - The first source with src_valid=1 gets src_ready=1. At most one ready bit is high per cycle.
  - Ready may depend on valid.
  - Sources hold valid, addr and data stable until the handshake.
- Pointer update: on a handshake with source g, p <= (g+1) mod NUM_SRC. With no handshake, p is unchanged.
- Output stage, 1-cycle latency:
  - Handshake in cycle N gives regCtrl_wen=1 in cycle N+1, with addr and data from the granted source. The register file writes on the N+1→N+2 edge.
  - Without a handshake in cycle N, regCtrl_wen=0 in N+1. Addr and data hold their previous values.
  - Throughput is one write per cycle with no bubbles.
- x0 handling:
  - A handshake with addr 0 is accepted and consumes the grant.
  - regCtrl_wen stays 0 for it, and no busy bit changes.
- Scoreboard:
  - Set: busy[alloc_addr] <= 1 when alloc_valid=1 and alloc_addr!=0.
  - Clear: busy[regCtrl_rdAddr] <= 0 on the edge where regCtrl_wen=1. This is the same edge the register file captures, so chk_busy reads 0 from the cycle the data is readable.
- Simultaneous events:
  - Set and clear of the same register in one cycle: set wins, and the bit stays 1.
  - flush=1 clears every busy bit and overrides set and clear in that cycle.
  - flush does not cancel a pending or registered write. Wen still fires.
- Busy bit 0 is always 0.
- chk_busy1/2 are pure lookups of the current busy register. They have no bypass of same-cycle set or clear.
- Reset mid-operation: a registered write is dropped (wen forced to 0 immediately) and the scoreboard is cleared.

Decomposition:
- Shared package holds:
  - NUM_REGS=32 and REG_ZERO=0
  - typedef reg_addr_t (ADDR_W bits) and xlen_t (XLEN bits)
  - typedef wb_req_t {valid, addr, data}
- One sub-module: rr_arbiter (NUM_SRC). Inputs are the request vector and pointer; output is a one-hot grant plus grant index.
- Scoreboard and output register stay in the top module.

Test Plan:
- Single source: src_valid=001, addr=5, data=0xDEAD in cycle 0 → src_ready=001 in cycle 0; wen=1, rdAddr=5, rdData=0xDEAD in cycle 1; wen=0 in cycle 2.
- Fairness: all three valid continuously for 6 cycles from p=0 → grant order 0,1,2,0,1,2, and wen high on 6 consecutive cycles.
- x0 write: source 1 writes addr 0, data 0xFF → ready=010, wen stays 0, p becomes 2.
- Scoreboard: alloc addr 7 in cycle 0 → chk_busy1(7)=1 from cycle 1. LSU handshake for addr 7 in cycle 3 → wen in cycle 4, chk_busy1=0 in cycle 5.
- Set/clear collision: wen to addr 9 while alloc_valid with addr 9 in the same cycle → busy_vec[9]=1 afterwards. Same cycle with flush=1 → busy_vec=0, and wen for the registered write still asserted.
- Async reset: with busy_vec=0x0000_0180 and wen=1, drive reset low mid-cycle → wen=0 and busy_vec=0 without a clock edge. After release, source 2 alone is granted first, then p=0.
